// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath micro-sequencer: FSM states,
// instruction field positions, opcode/op encodings and datapath control codes.
package datapath_ctrl_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WIMM   = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OPC_ALU = 3'b101,
    OPC_MOV = 3'b110
  } opcode_e;

  typedef enum logic [1:0] {
    OP_MOV_REG = 2'b00,
    OP_MOV_IMM = 2'b10
  } mov_op_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } alu_instr_op_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_class_e;

  function automatic logic [15:0] ext_imm8(input logic [7:0] imm, input logic sext);
    return sext ? {{8{imm[7]}}, imm} : {8'h00, imm};
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_decode.sv
// Purely combinational instruction decoder: splits fields, extends imm8 and
// classifies the instruction (unsupported encodings map to CLS_ILLEGAL).
module instr_decode
  import datapath_ctrl_pkg::*;
#(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic [15:0]  instr,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [15:0]  imm_ext,
  output instr_class_e cls,
  output logic         illegal
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc     = instr[OPC_MSB:OPC_LSB];
  assign op      = instr[OP_MSB:OP_LSB];
  assign rn      = instr[RN_MSB:RN_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rm      = instr[RM_MSB:RM_LSB];
  assign sh      = instr[SH_MSB:SH_LSB];
  assign imm_ext = ext_imm8(instr[IMM_MSB:IMM_LSB], IMM_SEXT);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc == OPC_MOV) begin
      if (op == OP_MOV_IMM) begin
        cls = CLS_MOV_IMM;
      end else if (op == OP_MOV_REG) begin
        cls = CLS_MOV_REG;
      end
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer expanding one 16-bit instruction per start/done
// handshake into the datapath's load-A / load-B / execute / write-back steps.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] datapath_in,
  output logic        wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op
);

  state_e       state_q, state_d;
  logic [15:0]  instr_q, instr_d;
  logic         illegal_q, illegal_d;

  logic [15:0]  dec_src;
  logic [2:0]   dec_rn, dec_rd, dec_rm;
  logic [1:0]   dec_sh;
  logic [15:0]  dec_imm;
  instr_class_e dec_cls;
  logic         dec_illegal;
  logic [1:0]   alu_sel;

  // In IDLE every output is 0, so the single decoder can look at the live
  // instruction there (to pick the next state) and at the captured one elsewhere.
  assign dec_src = (state_q == ST_IDLE) ? instr : instr_q;

  instr_decode #(
    .IMM_SEXT (IMM_SEXT)
  ) u_decode (
    .instr   (dec_src),
    .rn      (dec_rn),
    .rd      (dec_rd),
    .rm      (dec_rm),
    .sh      (dec_sh),
    .imm_ext (dec_imm),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          instr_d   = instr;
          illegal_d = dec_illegal;
          case (dec_cls)
            CLS_MOV_IMM:               state_d = ST_WIMM;
            CLS_ADD, CLS_CMP, CLS_AND: state_d = ST_LOAD_A;
            CLS_MOV_REG, CLS_MVN:      state_d = ST_LOAD_B;
            default:                   state_d = ST_DONE;
          endcase
        end
      end
      ST_WIMM:   state_d = ST_DONE;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC:   state_d = (dec_cls == CLS_CMP) ? ST_DONE : ST_WB;
      ST_WB:     state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // MOV reg is "0 + sh(Rm)", so it borrows the add opcode with A forced to 0.
  always_comb begin
    case (dec_cls)
      CLS_CMP: alu_sel = ALU_SUB;
      CLS_AND: alu_sel = ALU_AND;
      CLS_MVN: alu_sel = ALU_NOTB;
      default: alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    done        = 1'b0;
    illegal     = 1'b0;
    datapath_in = '0;
    wb_sel      = 1'b0;
    w_addr      = '0;
    w_en        = 1'b0;
    r_addr      = '0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_C        = 1'b0;
    en_status   = 1'b0;
    sel_A       = 1'b0;
    shift_op    = SH_NONE;
    ALU_op      = ALU_ADD;
    case (state_q)
      ST_WIMM: begin
        w_en        = 1'b1;
        wb_sel      = 1'b1;
        w_addr      = dec_rn;
        datapath_in = dec_imm;
      end
      ST_LOAD_A: begin
        r_addr = dec_rn;
        en_A   = 1'b1;
      end
      ST_LOAD_B: begin
        r_addr = dec_rm;
        en_B   = 1'b1;
      end
      ST_EXEC: begin
        shift_op  = dec_sh;
        ALU_op    = alu_sel;
        sel_A     = (dec_cls == CLS_MOV_REG);
        en_C      = (dec_cls != CLS_CMP);
        en_status = (dec_cls == CLS_CMP);
      end
      ST_WB: begin
        w_en     = 1'b1;
        w_addr   = dec_rd;
        shift_op = dec_sh;
        ALU_op   = alu_sel;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign sel_B = 1'b0;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: directed and random instructions checked cycle by
// cycle against a micro-op plan derived from the instruction set rules.
module tb_datapath_ctrl;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] dp_in;
    logic        wb_sel;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic        en_a;
    logic        en_b;
    logic        en_c;
    logic        en_status;
    logic        sel_a;
    logic        sel_b;
    logic [1:0]  shift_op;
    logic [1:0]  alu_op;
  } ov_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;

  logic        s_busy, s_done, s_illegal, s_wb_sel, s_w_en, s_en_A, s_en_B, s_en_C, s_en_status, s_sel_A, s_sel_B;
  logic [15:0] s_datapath_in;
  logic [2:0]  s_w_addr, s_r_addr;
  logic [1:0]  s_shift_op, s_ALU_op;
  logic        z_busy, z_done, z_illegal, z_wb_sel, z_w_en, z_en_A, z_en_B, z_en_C, z_en_status, z_sel_A, z_sel_B;
  logic [15:0] z_datapath_in;
  logic [2:0]  z_w_addr, z_r_addr;
  logic [1:0]  z_shift_op, z_ALU_op;

  ov_t obs_s, obs_z;
  int  total = 0;
  int  bad   = 0;

  datapath_ctrl #(.IMM_SEXT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .busy(s_busy), .done(s_done), .illegal(s_illegal), .datapath_in(s_datapath_in),
    .wb_sel(s_wb_sel), .w_addr(s_w_addr), .w_en(s_w_en), .r_addr(s_r_addr),
    .en_A(s_en_A), .en_B(s_en_B), .en_C(s_en_C), .en_status(s_en_status),
    .sel_A(s_sel_A), .sel_B(s_sel_B), .shift_op(s_shift_op), .ALU_op(s_ALU_op)
  );

  datapath_ctrl #(.IMM_SEXT(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .busy(z_busy), .done(z_done), .illegal(z_illegal), .datapath_in(z_datapath_in),
    .wb_sel(z_wb_sel), .w_addr(z_w_addr), .w_en(z_w_en), .r_addr(z_r_addr),
    .en_A(z_en_A), .en_B(z_en_B), .en_C(z_en_C), .en_status(z_en_status),
    .sel_A(z_sel_A), .sel_B(z_sel_B), .shift_op(z_shift_op), .ALU_op(z_ALU_op)
  );

  assign obs_s = {s_busy, s_done, s_illegal, s_datapath_in, s_wb_sel, s_w_addr, s_w_en, s_r_addr,
                  s_en_A, s_en_B, s_en_C, s_en_status, s_sel_A, s_sel_B, s_shift_op, s_ALU_op};
  assign obs_z = {z_busy, z_done, z_illegal, z_datapath_in, z_wb_sel, z_w_addr, z_w_en, z_r_addr,
                  z_en_A, z_en_B, z_en_C, z_en_status, z_sel_A, z_sel_B, z_shift_op, z_ALU_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Micro-op plan per instruction: W=write imm, A=load A, B=load B,
  // X=execute, R=write back C, D=done. Length equals the latency.
  function automatic string plan_of(input logic [15:0] ins);
    logic [2:0] opc;
    logic [1:0] op;
    opc = ins[15:13];
    op  = ins[12:11];
    if (opc == 3'b110 && op == 2'b10) return "WD";
    if (opc == 3'b110 && op == 2'b00) return "BXRD";
    if (opc == 3'b101 && op == 2'b01) return "ABXD";
    if (opc == 3'b101 && op == 2'b11) return "BXRD";
    if (opc == 3'b101) return "ABXRD";
    return "D";
  endfunction

  function automatic ov_t model_step(input logic [15:0] ins, input bit sext, input byte step);
    ov_t e;
    logic       is_alu, is_cmp, is_movr;
    logic [7:0] imm;
    e       = '0;
    imm     = ins[7:0];
    is_alu  = (ins[15:13] == 3'b101);
    is_cmp  = is_alu && (ins[12:11] == 2'b01);
    is_movr = (ins[15:13] == 3'b110) && (ins[12:11] == 2'b00);
    e.busy  = 1'b1;
    case (step)
      "W": begin
        e.w_en   = 1'b1;
        e.wb_sel = 1'b1;
        e.w_addr = ins[10:8];
        e.dp_in  = (sext && imm[7]) ? (16'hFF00 | 16'(imm)) : 16'(imm);
      end
      "A": begin
        e.r_addr = ins[10:8];
        e.en_a   = 1'b1;
      end
      "B": begin
        e.r_addr = ins[2:0];
        e.en_b   = 1'b1;
      end
      "X": begin
        e.shift_op  = ins[4:3];
        e.alu_op    = is_alu ? ins[12:11] : 2'b00;
        e.sel_a     = is_movr;
        e.en_c      = !is_cmp;
        e.en_status = is_cmp;
      end
      "R": begin
        e.w_en     = 1'b1;
        e.w_addr   = ins[7:5];
        e.shift_op = ins[4:3];
        e.alu_op   = is_alu ? ins[12:11] : 2'b00;
      end
      "D": begin
        e.done    = 1'b1;
        e.illegal = (plan_of(ins) == "D");
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input ov_t got, input ov_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts from a negedge; leaves off at the negedge of the done cycle.
  task automatic run_instr(input logic [15:0] ins);
    string p;
    p = plan_of(ins);
    @(negedge clk);
    chk($sformatf("idle_s %h", ins), obs_s, '0);
    chk($sformatf("idle_z %h", ins), obs_z, '0);
    start = 1'b1;
    instr = ins;
    for (int k = 0; k < p.len(); k++) begin
      @(negedge clk);
      chk($sformatf("sext %h cyc%0d", ins, k + 1), obs_s, model_step(ins, 1'b1, p[k]));
      chk($sformatf("zext %h cyc%0d", ins, k + 1), obs_z, model_step(ins, 1'b0, p[k]));
      $display("instr=%h cyc=%0d step=%s busy=%b done=%b", ins, k + 1, p.substr(k, k), s_busy, s_done);
      // Noise on start/instr while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      instr = 16'($urandom);
    end
  endtask

  initial begin
    logic [15:0] r;
    rst_n = 1'b0;
    start = 1'b0;
    instr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_s", obs_s, '0);
    chk("reset_z", obs_z, '0);
    start = 1'b1;
    instr = 16'hD3FB;
    @(negedge clk);
    chk("reset_start_s", obs_s, '0);
    start = 1'b0;
    rst_n = 1'b1;

    run_instr(16'hD3FB);
    run_instr(16'hA148);
    run_instr(16'hAD06);
    run_instr(16'hB8FC);
    run_instr(16'hE000);
    run_instr(16'hC0A9);
    run_instr(16'hB4E3);
    run_instr(16'hD27F);
    run_instr(16'hC800);

    // Reset asserted mid-EXEC of an ADD.
    @(negedge clk);
    chk("pre_rst_idle", obs_s, '0);
    start = 1'b1;
    instr = 16'hA148;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_seq cyc%0d", k + 1), obs_s, model_step(16'hA148, 1'b1, byte'("ABX" >> (8 * (2 - k)))));
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_s", obs_s, '0);
    chk("async_rst_z", obs_z, '0);
    @(negedge clk);
    chk("rst_held_s", obs_s, '0);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:13] = 3'b110;
        1, 2: r[15:13] = 3'b101;
        default: ;
      endcase
      run_instr(r);
    end

    @(negedge clk);
    chk("final_idle", obs_s, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
